// File: rtl/sha_mem_responder.sv
// rtl/sha_mem_responder.sv - word-memory responder and result drainer for the hash core
module sha_mem_responder #(
  parameter int          DEPTH    = 256,
  parameter logic [15:0] MSG_ADDR = 16'h0000,
  parameter logic [15:0] OUT_ADDR = 16'h0040,
  parameter int          NUM_OUT  = 16,
  parameter int          TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic        host_go,
  output logic        host_ready,
  output logic        core_start,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_last,
  input  logic        res_ready,
  output logic        busy,
  output logic        err_range,
  output logic        err_timeout,
  output logic [15:0] wr_count
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT - 1);
  localparam logic [15:0] LAST_IDX = 16'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0] mem [DEPTH];

  logic          core_in_range;
  logic          host_in_range;
  logic [AW-1:0] core_idx;
  logic [AW-1:0] host_idx;
  logic [AW-1:0] drain_mem_idx;
  logic          run_entry;
  logic          drain_entry;
  logic          wd_expire;
  logic          beat_accept;
  logic [31:0]   wd_cnt;
  logic [15:0]   drain_idx;
  logic          drain_prime;

  assign core_in_range = {1'b0, mem_addr} < DEPTH_L;
  assign host_in_range = {1'b0, host_addr} < DEPTH_L;
  assign core_idx      = mem_addr[AW-1:0];
  assign host_idx      = host_addr[AW-1:0];
  // Drain walks OUT_ADDR upward and wraps inside the memory.
  assign drain_mem_idx = AW'((32'(OUT_ADDR) + 32'(drain_idx)) % 32'(DEPTH));

  assign core_message_addr = MSG_ADDR;
  assign core_output_addr  = OUT_ADDR;
  assign host_ready        = (state == ST_IDLE) || (state == ST_DONE);
  assign busy              = (state == ST_RUN) || (state == ST_DRAIN);
  assign beat_accept       = (state == ST_DRAIN) && res_valid && res_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; done in the expiry cycle takes precedence over the watchdog.
  always_comb begin
    next_state  = state;
    wd_expire   = 1'b0;
    run_entry   = 1'b0;
    drain_entry = 1'b0;
    case (state)
      ST_IDLE: begin
        if (host_go) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (core_done) begin
          next_state = ST_DRAIN;
        end else if (wd_cnt == WD_LAST) begin
          wd_expire  = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (beat_accept && res_last) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (host_go) next_state = ST_RUN;
      end
      default: next_state = ST_IDLE;
    endcase
    run_entry   = (state != ST_RUN) && (next_state == ST_RUN);
    drain_entry = (state == ST_RUN) && (next_state == ST_DRAIN);
  end

  // Memory array: host owns it in IDLE, the core in RUN; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && host_we && host_in_range) begin
      mem[host_idx] <= host_wdata;
    end else if (state == ST_RUN && mem_we && core_in_range) begin
      mem[core_idx] <= mem_write_data;
    end
  end

  // Core read port, start pulse, counters and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_start    <= 1'b0;
      mem_read_data <= 32'd0;
      err_range     <= 1'b0;
      err_timeout   <= 1'b0;
      wr_count      <= 16'd0;
      wd_cnt        <= 32'd0;
    end else begin
      core_start <= run_entry;
      if (state == ST_RUN && core_in_range) begin
        mem_read_data <= mem[core_idx];
      end else begin
        mem_read_data <= 32'd0;
      end
      if (state == ST_IDLE && host_we && !host_in_range) begin
        err_range <= 1'b1;
      end
      if (state == ST_RUN) begin
        wd_cnt <= wd_cnt + 32'd1;
        if (!core_in_range) err_range <= 1'b1;
        if (mem_we && core_in_range && wr_count != 16'hFFFF) begin
          wr_count <= wr_count + 16'd1;
        end
        if (wd_expire) err_timeout <= 1'b1;
      end
      if (run_entry) begin
        wd_cnt      <= 32'd0;
        wr_count    <= 16'd0;
        err_range   <= 1'b0;
        err_timeout <= 1'b0;
      end
    end
  end

  // Result drain: one priming cycle after entry, then load/hold/accept with a one-cycle gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid   <= 1'b0;
      res_data    <= 32'd0;
      res_last    <= 1'b0;
      drain_idx   <= 16'd0;
      drain_prime <= 1'b0;
    end else if (drain_entry) begin
      res_valid   <= 1'b0;
      res_last    <= 1'b0;
      drain_idx   <= 16'd0;
      drain_prime <= 1'b1;
    end else if (state == ST_DRAIN) begin
      if (res_valid) begin
        if (res_ready) begin
          res_valid <= 1'b0;
          res_last  <= 1'b0;
          drain_idx <= drain_idx + 16'd1;
        end
      end else if (drain_prime) begin
        drain_prime <= 1'b0;
      end else begin
        res_data  <= mem[drain_mem_idx];
        res_valid <= 1'b1;
        res_last  <= (drain_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
// tb/tb_sha_mem_responder.sv - randomized self-checking bench for sha_mem_responder
module tb_sha_mem_responder;

  localparam int          DEPTH    = 256;
  localparam logic [15:0] OUT_ADDR = 16'h0040;
  localparam int          NUM_OUT  = 16;
  localparam int          TIMEOUT  = 100;

  logic        clk;
  logic        reset_n;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_go;
  logic        host_ready;
  logic        core_start;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic        core_done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_last;
  logic        res_ready;
  logic        busy;
  logic        err_range;
  logic        err_timeout;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] ref_mem [DEPTH];

  sha_mem_responder #(
    .DEPTH   (DEPTH),
    .MSG_ADDR(16'h0000),
    .OUT_ADDR(OUT_ADDR),
    .NUM_OUT (NUM_OUT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .host_we          (host_we),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_go          (host_go),
    .host_ready       (host_ready),
    .core_start       (core_start),
    .core_message_addr(core_message_addr),
    .core_output_addr (core_output_addr),
    .core_done        (core_done),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .res_valid        (res_valid),
    .res_data         (res_data),
    .res_last         (res_last),
    .res_ready        (res_ready),
    .busy             (busy),
    .err_range        (err_range),
    .err_timeout      (err_timeout),
    .wr_count         (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
  endtask

  // Called one step after the edge that entered DRAIN; accepts stop_after beats.
  task automatic drain_check(input int stall_beat, input int stall_len, input int stop_after);
    logic [31:0] exp;
    res_ready = 1'b0;
    check("drain_entry_valid", res_valid, 0);
    tick();
    check("drain_prime_valid", res_valid, 0);
    tick();
    for (int b = 0; b < stop_after; b++) begin
      exp = ref_mem[(int'(OUT_ADDR) + b) % DEPTH];
      check("beat_valid", res_valid, 1);
      check("beat_data", res_data, exp);
      check("beat_last", res_last, (b == NUM_OUT - 1) ? 1 : 0);
      if (b == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_valid", res_valid, 1);
          check("stall_data", res_data, exp);
          check("stall_last", res_last, (b == NUM_OUT - 1) ? 1 : 0);
        end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("gap_valid", res_valid, 0);
      if (b == NUM_OUT - 1) begin
        check("end_host_ready", host_ready, 1);
        check("end_busy", busy, 0);
        tick();
        check("after_end_valid", res_valid, 0);
      end else if (b < stop_after - 1) begin
        tick();
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_last"}, res_last, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_host_ready"}, host_ready, 1);
    check({tag, "_err_range"}, err_range, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_mem_read_data"}, mem_read_data, 0);
    check({tag, "_wr_count"}, wr_count, 0);
    check({tag, "_msg_addr"}, core_message_addr, 16'h0000);
    check({tag, "_out_addr"}, core_output_addr, OUT_ADDR);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [31:0] exp_rd;
    int          a;
    int          nwr;
    int          stall;

    reset_n        = 1'b0;
    host_we        = 1'b0;
    host_addr      = 16'd0;
    host_wdata     = 32'd0;
    host_go        = 1'b0;
    core_done      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'd0;
    mem_write_data = 32'd0;
    res_ready      = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Run A: full preload, start pulse, read latency, 16 result writes, stalled drain.
    for (int i = 0; i < DEPTH; i++) begin
      w = (i == 3) ? 32'hDEADBEEF : $urandom;
      host_we    = 1'b1;
      host_addr  = 16'(i);
      host_wdata = w;
      ref_mem[i] = w;
      tick();
    end
    host_we = 1'b0;
    launch();
    check("start_pulse_hi", core_start, 1);
    check("run_busy", busy, 1);
    check("run_host_ready", host_ready, 0);
    mem_addr = 16'd3;
    tick();
    check("start_pulse_lo", core_start, 0);
    check("read_latency", mem_read_data, 32'hDEADBEEF);
    for (int k = 0; k < NUM_OUT; k++) begin
      mem_we         = 1'b1;
      mem_addr       = OUT_ADDR + 16'(k);
      mem_write_data = 32'h1000 + 32'(k);
      ref_mem[int'(OUT_ADDR) + k] = 32'h1000 + 32'(k);
      tick();
    end
    mem_we    = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("a_wr_count", wr_count, 16);
    check("a_drain_busy", busy, 1);
    drain_check(1, 5, NUM_OUT);

    // Run B from DONE: read-before-write, core range error, reset after 3 beats.
    launch();
    check("b_start", core_start, 1);
    check("b_err_clear", err_range, 0);
    w              = $urandom;
    mem_addr       = 16'd5;
    mem_we         = 1'b1;
    mem_write_data = w;
    tick();
    check("rd_before_wr", mem_read_data, ref_mem[5]);
    ref_mem[5]     = w;
    mem_addr       = 16'(DEPTH);
    mem_write_data = ~ref_mem[0];
    tick();
    check("oor_read_zero", mem_read_data, 0);
    check("core_err_range", err_range, 1);
    mem_we   = 1'b0;
    mem_addr = 16'd0;
    tick();
    check("oor_write_dropped", mem_read_data, ref_mem[0]);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("b_wr_count", wr_count, 1);
    check("b_err_sticky", err_range, 1);
    drain_check(-1, 0, 3);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_drain_reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Run C: host range error in IDLE, write+go in one cycle, full re-drain.
    host_we    = 1'b1;
    host_addr  = 16'(DEPTH + 1);
    host_wdata = ~ref_mem[1];
    tick();
    host_we = 1'b0;
    check("host_err_range", err_range, 1);
    w          = $urandom;
    host_we    = 1'b1;
    host_addr  = 16'd7;
    host_wdata = w;
    ref_mem[7] = w;
    launch();
    host_we = 1'b0;
    check("c_start", core_start, 1);
    check("c_err_cleared", err_range, 0);
    mem_addr = 16'd1;
    tick();
    check("host_oor_dropped", mem_read_data, ref_mem[1]);
    mem_addr = 16'd7;
    tick();
    check("write_with_go", mem_read_data, w);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("c_wr_count", wr_count, 0);
    stall = $urandom_range(0, NUM_OUT - 1);
    drain_check(stall, $urandom_range(1, 4), NUM_OUT);

    // Host write in DONE must be ignored.
    host_we    = 1'b1;
    host_addr  = OUT_ADDR;
    host_wdata = ~ref_mem[int'(OUT_ADDR)];
    tick();
    host_we = 1'b0;

    // Run D: random core traffic with done never raised -> watchdog.
    launch();
    nwr = 0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      a              = $urandom_range(0, DEPTH - 1);
      mem_addr       = 16'(a);
      mem_we         = 1'($urandom_range(0, 1));
      mem_write_data = $urandom;
      exp_rd         = ref_mem[a];
      if (mem_we) begin
        ref_mem[a] = mem_write_data;
        nwr++;
      end
      if (c == TIMEOUT) begin
        check("wd_last_busy", busy, 1);
        check("wd_last_no_timeout", err_timeout, 0);
      end
      tick();
      if (c < TIMEOUT) check("rand_read", mem_read_data, exp_rd);
    end
    mem_we = 1'b0;
    check("wd_timeout", err_timeout, 1);
    check("wd_done_busy", busy, 0);
    check("wd_done_ready", host_ready, 1);
    check("wd_no_valid", res_valid, 0);
    check("wd_wr_count", wr_count, nwr);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wd_idle_valid", res_valid, 0);
      check("wd_idle_rdata", mem_read_data, 0);
      check("wd_hold_timeout", err_timeout, 1);
    end

    // Run E: immediate done, drain reflects all earlier core writes.
    launch();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("e_timeout_cleared", err_timeout, 0);
    check("e_wr_count", wr_count, 0);
    stall = $urandom_range(0, NUM_OUT - 1);
    drain_check(stall, $urandom_range(1, 6), NUM_OUT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
